// File: rtl/eb_upsize_if.sv
// -----------------------------------------------------------------------------
// eb_upsize_if
//
// Purpose:
//   Bundles the narrow upstream (t_0_*) and wide downstream (i_0_*) req/ack
//   channels of the eb_upsize width upsizer into one interface.
//
// Parameters:
//   WIDTH  width of one narrow beat in bits
//   RATIO  number of narrow beats per wide word
//
// Signals:
//   t_0_req   upstream beat valid                   (master -> slave)
//   t_0_ack   upstream beat accepted                (slave  -> master)
//   t_0_dat   upstream beat data, WIDTH bits        (master -> slave)
//   i_0_req   packed word valid                     (slave  -> master)
//   i_0_ack   downstream ready                      (master -> slave)
//   i_0_dat   packed word, WIDTH*RATIO bits         (slave  -> master)
//   t_0_last  final beat of a packet                (EB_UPSIZE_LAST_EN only)
//   i_0_len   valid beats in packed word            (EB_UPSIZE_LAST_EN only)
//
// Modports:
//   master  the environment: drives the upstream beats and downstream ready
//   slave   the upsizer itself
//
// Optional feature macro: EB_UPSIZE_LAST_EN
// -----------------------------------------------------------------------------
interface eb_upsize_if #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
);
    localparam int LEN_W = $clog2(RATIO) + 1;

    logic                   t_0_req;
    logic                   t_0_ack;
    logic [WIDTH-1:0]       t_0_dat;
    logic                   i_0_req;
    logic                   i_0_ack;
    logic [WIDTH*RATIO-1:0] i_0_dat;
`ifdef EB_UPSIZE_LAST_EN
    logic                   t_0_last;
    logic [LEN_W-1:0]       i_0_len;

    modport master (
        output t_0_req, t_0_dat, t_0_last, i_0_ack,
        input  t_0_ack, i_0_req, i_0_dat, i_0_len
    );

    modport slave (
        input  t_0_req, t_0_dat, t_0_last, i_0_ack,
        output t_0_ack, i_0_req, i_0_dat, i_0_len
    );
`else
    modport master (
        output t_0_req, t_0_dat, i_0_ack,
        input  t_0_ack, i_0_req, i_0_dat
    );

    modport slave (
        input  t_0_req, t_0_dat, i_0_ack,
        output t_0_ack, i_0_req, i_0_dat
    );
`endif
endinterface

// File: rtl/eb_upsize.sv
// -----------------------------------------------------------------------------
// eb_upsize
//
// Purpose:
//   Elastic width upsizer. Packs RATIO consecutive WIDTH-bit beats into one
//   WIDTH*RATIO-bit word, beat 0 in the least significant lane. Intended to sit
//   directly downstream of a 2-entry elastic buffer stage. Accepts one narrow
//   beat per cycle without bubbles while downstream is ready; the packed word
//   is presented the cycle after its last beat is accepted.
//
// Parameters:
//   WIDTH  width of one narrow beat in bits (default 8)
//   RATIO  beats per packed word, legal range 2..16 (default 4)
//
// Ports:
//   clk      clock, rising edge
//   reset_n  asynchronous, active-low reset
//   bus      eb_upsize_if.slave: t_0_req/t_0_ack/t_0_dat upstream,
//            i_0_req/i_0_ack/i_0_dat downstream
//            (+ t_0_last / i_0_len with EB_UPSIZE_LAST_EN)
//
// Optional feature macro: EB_UPSIZE_LAST_EN
//   Adds packet framing: a beat with t_0_last=1 closes the word early, the
//   unused upper lanes are zero-filled and i_0_len reports the beat count.
// -----------------------------------------------------------------------------
module eb_upsize #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    eb_upsize_if.slave bus
);
    localparam int CNT_W = $clog2(RATIO);
    localparam int LEN_W = CNT_W + 1;
    localparam int ACC_W = (RATIO - 1) * WIDTH;
    localparam int OUT_W = RATIO * WIDTH;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    generate
        if (RATIO < 2 || RATIO > 16) begin : g_bad_ratio
            $error("eb_upsize: RATIO must be in 2..16");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_reg,  cnt_next;
    logic             full_reg, full_next;
    logic [ACC_W-1:0] acc_reg,  acc_next;
    logic [OUT_W-1:0] out_reg,  out_next;
`ifdef EB_UPSIZE_LAST_EN
    logic [LEN_W-1:0] len_reg,  len_next;
`endif

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic             cnt_is_last;
    logic             ack_int;
    logic             accept;
    logic             word_end;
    logic             word_load;
    logic             out_fire;
    logic [OUT_W-1:0] word_next;

    assign cnt_is_last = (cnt_reg == LAST_CNT);

`ifdef EB_UPSIZE_LAST_EN
    // A beat that closes a word (last lane or packet end) needs the output
    // register; every other beat only touches the accumulator and never stalls.
    assign ack_int  = (~cnt_is_last & ~bus.t_0_last) | ~full_reg | bus.i_0_ack;
    assign word_end = cnt_is_last | bus.t_0_last;
`else
    assign ack_int  = ~cnt_is_last | ~full_reg | bus.i_0_ack;
    assign word_end = cnt_is_last;
`endif

    assign accept    = bus.t_0_req & ack_int;
    assign word_load = accept & word_end;
    assign out_fire  = full_reg & bus.i_0_ack;

    // -------------------------------------------------------------------------
    // Word assembly: the closing beat goes straight into the output register
    // alongside the accumulated lanes, so it never occupies the accumulator.
    // -------------------------------------------------------------------------
`ifdef EB_UPSIZE_LAST_EN
    // Early flush: lanes below cnt come from the accumulator, lane cnt is the
    // incoming beat, lanes above cnt are zero-filled (stale accumulator
    // contents from an earlier word must not leak out).
    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            if (gi < RATIO - 1) begin : g_acc_lane
                assign word_next[gi*WIDTH +: WIDTH] =
                    (CNT_W'(gi) < cnt_reg)  ? acc_reg[gi*WIDTH +: WIDTH] :
                    (CNT_W'(gi) == cnt_reg) ? bus.t_0_dat :
                                              '0;
            end else begin : g_top_lane
                assign word_next[gi*WIDTH +: WIDTH] =
                    cnt_is_last ? bus.t_0_dat : '0;
            end
        end
    endgenerate
`else
    // Full words only: every accumulator lane has been written for this word.
    assign word_next = {bus.t_0_dat, acc_reg};
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_next  = cnt_reg;
        full_next = full_reg;
        acc_next  = acc_reg;
        out_next  = out_reg;
`ifdef EB_UPSIZE_LAST_EN
        len_next  = len_reg;
`endif

        if (accept) begin
            if (word_end) begin
                // Accumulator is intentionally left as is: every lane is
                // rewritten (or zero-masked) before it is used again.
                cnt_next = '0;
                out_next = word_next;
`ifdef EB_UPSIZE_LAST_EN
                len_next = LEN_W'(cnt_reg) + LEN_W'(1);
`endif
            end else begin
                for (int j = 0; j < RATIO - 1; j++) begin
                    if (cnt_reg == CNT_W'(j)) begin
                        acc_next[j*WIDTH +: WIDTH] = bus.t_0_dat;
                    end
                end
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end

        // A reload in the same cycle as the downstream transfer keeps the
        // register occupied, giving back-to-back words.
        if (word_load) begin
            full_next = 1'b1;
        end else if (out_fire) begin
            full_next = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg  <= '0;
            full_reg <= 1'b0;
            acc_reg  <= '0;
            out_reg  <= '0;
`ifdef EB_UPSIZE_LAST_EN
            len_reg  <= '0;
`endif
        end else begin
            cnt_reg  <= cnt_next;
            full_reg <= full_next;
            acc_reg  <= acc_next;
            out_reg  <= out_next;
`ifdef EB_UPSIZE_LAST_EN
            len_reg  <= len_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.t_0_ack = ack_int;
    assign bus.i_0_req = full_reg;
    assign bus.i_0_dat = out_reg;
`ifdef EB_UPSIZE_LAST_EN
    assign bus.i_0_len = len_reg;
`endif

endmodule

// File: tb/tb_eb_upsize.sv
// -----------------------------------------------------------------------------
// tb_eb_upsize
//
// Self-checking bench for eb_upsize (WIDTH=8, RATIO=4). Inputs are driven on
// the falling edge and outputs observed 1 ns later; a handshake seen there
// completes on the following rising edge. Accepted beats and delivered words
// are logged in queues; expected words are rebuilt from the beat log by plain
// lane packing. Works with or without EB_UPSIZE_LAST_EN.
// -----------------------------------------------------------------------------
module tb_eb_upsize;
    localparam int WIDTH = 8;
    localparam int RATIO = 4;
    localparam int LEN_W = $clog2(RATIO) + 1;
    localparam int OUT_W = WIDTH * RATIO;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    eb_upsize_if #(.WIDTH(WIDTH), .RATIO(RATIO)) bus ();

    eb_upsize #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Observations from the most recent cycle
    logic             obs_t_ack;
    logic             obs_i_req;
    logic [OUT_W-1:0] obs_i_dat;
    logic [LEN_W-1:0] obs_len;

    // Transaction logs
    logic [WIDTH-1:0] beat_q[$];
    bit               last_q[$];
    logic [OUT_W-1:0] word_q[$];
    logic [LEN_W-1:0] len_q[$];

    // Reference output built from the beat log
    logic [OUT_W-1:0] exp_w[$];
    logic [LEN_W-1:0] exp_l[$];

    // One clock of stimulus; logs the handshakes that complete at the next edge.
    task automatic cycle(input bit req, input logic [WIDTH-1:0] dat,
                         input bit last, input bit iack);
        @(negedge clk);
        bus.t_0_req = req;
        bus.t_0_dat = dat;
`ifdef EB_UPSIZE_LAST_EN
        bus.t_0_last = last;
`endif
        bus.i_0_ack = iack;
        #1;
        obs_t_ack = bus.t_0_ack;
        obs_i_req = bus.i_0_req;
        obs_i_dat = bus.i_0_dat;
`ifdef EB_UPSIZE_LAST_EN
        obs_len = bus.i_0_len;
`else
        obs_len = '0;
`endif
        if (req && obs_t_ack) begin
            beat_q.push_back(dat);
            last_q.push_back(last);
        end
        if (obs_i_req && iack) begin
            word_q.push_back(obs_i_dat);
            len_q.push_back(obs_len);
        end
    endtask

    task automatic clear_logs();
        beat_q.delete();
        last_q.delete();
        word_q.delete();
        len_q.delete();
    endtask

    task automatic idle_inputs();
        bus.t_0_req = 1'b0;
        bus.t_0_dat = '0;
`ifdef EB_UPSIZE_LAST_EN
        bus.t_0_last = 1'b0;
`endif
        bus.i_0_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        clear_logs();
    endtask

    // Packs the beat log into words: RATIO beats per word, or fewer when a
    // beat carries the packet-end flag; unused lanes read as zero. A trailing
    // partial word is not emitted.
    task automatic model_pack();
        logic [OUT_W-1:0] w;
        int k;
        exp_w.delete();
        exp_l.delete();
        w = '0;
        k = 0;
        for (int i = 0; i < beat_q.size(); i++) begin
            w[k*WIDTH +: WIDTH] = beat_q[i];
            k++;
            if (k == RATIO || last_q[i]) begin
                exp_w.push_back(w);
                exp_l.push_back(LEN_W'(k));
                w = '0;
                k = 0;
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        logic [OUT_W-1:0] w;
        // Still inside the power-on reset
        #1;
        total++;
        if (bus.i_0_req !== 1'b0) begin
            bad++; $display("FAIL reset_req: got %b expected 0", bus.i_0_req);
        end
        total++;
        if (bus.i_0_dat !== '0) begin
            bad++; $display("FAIL reset_dat: got %h expected 0", bus.i_0_dat);
        end
        total++;
        if (bus.t_0_ack !== 1'b1) begin
            bad++; $display("FAIL reset_ack: got %b expected 1", bus.t_0_ack);
        end
`ifdef EB_UPSIZE_LAST_EN
        total++;
        if (bus.i_0_len !== '0) begin
            bad++; $display("FAIL reset_len: got %0d expected 0", bus.i_0_len);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        clear_logs();

        // One full word held, then three more beats: last lane stalls.
        for (int i = 0; i < 7; i++) cycle(1'b1, WIDTH'(i + 1), 1'b0, 1'b0);
        cycle(1'b1, 8'h08, 1'b0, 1'b0);
        total++;
        if (obs_t_ack !== 1'b0 || obs_i_req !== 1'b1) begin
            bad++; $display("FAIL pre_reset_stall: got ack=%b req=%b expected ack=0 req=1",
                            obs_t_ack, obs_i_req);
        end

        // Asynchronous reset between clock edges
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.i_0_req !== 1'b0 || bus.i_0_dat !== '0 || bus.t_0_ack !== 1'b1) begin
            bad++; $display("FAIL async_reset: got req=%b dat=%h ack=%b expected req=0 dat=0 ack=1",
                            bus.i_0_req, bus.i_0_dat, bus.t_0_ack);
        end
        #1;
        reset_n = 1'b1;
        clear_logs();

        // Fresh word after the discarded partial
        for (int i = 0; i < RATIO; i++) cycle(1'b1, WIDTH'(8'hA1 + i), 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        w = 32'hA4A3A2A1;
        total++;
        if (obs_i_req !== 1'b1 || obs_i_dat !== w) begin
            bad++; $display("FAIL reset_fresh_word: got req=%b dat=%h expected req=1 dat=%h",
                            obs_i_req, obs_i_dat, w);
        end
        $display("test_reset done");
    endtask

    // -------------------------------------------------------------------------
    task automatic test_pack();
        logic [WIDTH-1:0] vals[4];
        logic [OUT_W-1:0] w;
        do_reset();
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, vals[i], 1'b0, 1'b1);
            total++;
            if (obs_i_req !== 1'b0) begin
                bad++; $display("FAIL pack_early_req beat %0d: got %b expected 0", i, obs_i_req);
            end
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        w = 32'h44332211;
        total++;
        if (obs_i_req !== 1'b1 || obs_i_dat !== w) begin
            bad++; $display("FAIL pack_word: got req=%b dat=%h expected req=1 dat=%h",
                            obs_i_req, obs_i_dat, w);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        total++;
        if (obs_i_req !== 1'b0) begin
            bad++; $display("FAIL pack_drained: got req=%b expected 0", obs_i_req);
        end
        $display("test_pack done: word=%h", w);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_back_to_back();
        bit exp_req;
        do_reset();
        for (int i = 0; i <= 12; i++) begin
            if (i < 12) cycle(1'b1, WIDTH'($urandom), 1'b0, 1'b1);
            else        cycle(1'b0, '0, 1'b0, 1'b1);
            exp_req = (i > 0) && (i % RATIO == 0);
            if (i < 12) begin
                total++;
                if (obs_t_ack !== 1'b1) begin
                    bad++; $display("FAIL b2b_ack cycle %0d: got %b expected 1", i, obs_t_ack);
                end
            end
            total++;
            if (obs_i_req !== exp_req) begin
                bad++; $display("FAIL b2b_req cycle %0d: got %b expected %b", i, obs_i_req, exp_req);
            end
        end
        model_pack();
        total++;
        if (word_q.size() != 3 || exp_w.size() != 3) begin
            bad++; $display("FAIL b2b_count: got %0d words expected 3 (model %0d)",
                            word_q.size(), exp_w.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (word_q[k] !== exp_w[k]) begin
                    bad++; $display("FAIL b2b_word %0d: got %h expected %h", k, word_q[k], exp_w[k]);
                end
            end
        end
        $display("test_back_to_back done: words=%0d", word_q.size());
    endtask

    // -------------------------------------------------------------------------
    task automatic test_backpressure();
        logic [WIDTH-1:0] b[8];
        logic [OUT_W-1:0] w1, w2;
        do_reset();
        for (int i = 0; i < 8; i++) b[i] = WIDTH'($urandom);
        w1 = {b[3], b[2], b[1], b[0]};
        w2 = {b[7], b[6], b[5], b[4]};
        for (int i = 0; i < 4; i++) cycle(1'b1, b[i], 1'b0, 1'b0);
        for (int i = 4; i < 7; i++) begin
            cycle(1'b1, b[i], 1'b0, 1'b0);
            total++;
            if (obs_t_ack !== 1'b1 || obs_i_req !== 1'b1 || obs_i_dat !== w1) begin
                bad++; $display("FAIL bp_partial beat %0d: got ack=%b req=%b dat=%h expected ack=1 req=1 dat=%h",
                                i, obs_t_ack, obs_i_req, obs_i_dat, w1);
            end
        end
        for (int s = 0; s < 3; s++) begin
            cycle(1'b1, b[7], 1'b0, 1'b0);
            total++;
            if (obs_t_ack !== 1'b0 || obs_i_req !== 1'b1 || obs_i_dat !== w1) begin
                bad++; $display("FAIL bp_stall %0d: got ack=%b req=%b dat=%h expected ack=0 req=1 dat=%h",
                                s, obs_t_ack, obs_i_req, obs_i_dat, w1);
            end
        end
        cycle(1'b1, b[7], 1'b0, 1'b1);
        total++;
        if (obs_t_ack !== 1'b1 || obs_i_req !== 1'b1 || obs_i_dat !== w1) begin
            bad++; $display("FAIL bp_release: got ack=%b req=%b dat=%h expected ack=1 req=1 dat=%h",
                            obs_t_ack, obs_i_req, obs_i_dat, w1);
        end
        cycle(1'b0, '0, 1'b0, 1'b0);
        total++;
        if (obs_i_req !== 1'b1 || obs_i_dat !== w2) begin
            bad++; $display("FAIL bp_next_word: got req=%b dat=%h expected req=1 dat=%h",
                            obs_i_req, obs_i_dat, w2);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        $display("test_backpressure done: w1=%h w2=%h", w1, w2);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_random();
        int  cyc;
        bit  req, iack, last;
        bit  prev_hold;
        logic [OUT_W-1:0] prev_dat;
        logic [LEN_W-1:0] prev_len;
        do_reset();
        cyc = 0;
        prev_hold = 1'b0;
        prev_dat = '0;
        prev_len = '0;
        while (beat_q.size() < 1000 && cyc < 20000) begin
            req  = ($urandom_range(0, 9) < 7);
            iack = ($urandom_range(0, 9) < 6);
`ifdef EB_UPSIZE_LAST_EN
            last = ($urandom_range(0, 5) == 0);
`else
            last = 1'b0;
`endif
            cycle(req, WIDTH'($urandom), last, iack);
            if (prev_hold) begin
                total++;
                if (obs_i_req !== 1'b1 || obs_i_dat !== prev_dat || obs_len !== prev_len) begin
                    bad++; $display("FAIL rand_hold cycle %0d: got req=%b dat=%h expected req=1 dat=%h",
                                    cyc, obs_i_req, obs_i_dat, prev_dat);
                end
            end
            prev_hold = obs_i_req && !iack;
            prev_dat  = obs_i_dat;
            prev_len  = obs_len;
            cyc++;
        end
        total++;
        if (beat_q.size() < 1000) begin
            bad++; $display("FAIL rand_timeout: got %0d beats expected 1000", beat_q.size());
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        model_pack();
        total++;
        if (word_q.size() != exp_w.size()) begin
            bad++; $display("FAIL rand_count: got %0d words expected %0d", word_q.size(), exp_w.size());
        end else begin
            for (int k = 0; k < exp_w.size(); k++) begin
                total++;
                if (word_q[k] !== exp_w[k] || len_q[k] !== exp_l[k]
`ifndef EB_UPSIZE_LAST_EN
                    && 1'b1 && (len_q[k] === len_q[k]) && (exp_l[k] !== exp_l[k])
`endif
                   ) begin
                    bad++; $display("FAIL rand_word %0d: got %h/len %0d expected %h/len %0d",
                                    k, word_q[k], len_q[k], exp_w[k], exp_l[k]);
                end
            end
        end
        $display("test_random done: beats=%0d words=%0d cycles=%0d", beat_q.size(), word_q.size(), cyc);
    endtask

`ifdef EB_UPSIZE_LAST_EN
    // -------------------------------------------------------------------------
    task automatic test_last();
        logic [OUT_W-1:0] w;
        do_reset();
        cycle(1'b1, 8'hAA, 1'b0, 1'b1);
        cycle(1'b1, 8'hBB, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        w = 32'h0000BBAA;
        total++;
        if (obs_i_req !== 1'b1 || obs_i_dat !== w || obs_len !== LEN_W'(2)) begin
            bad++; $display("FAIL last_short: got req=%b dat=%h len=%0d expected req=1 dat=%h len=2",
                            obs_i_req, obs_i_dat, obs_len, w);
        end
        for (int i = 0; i < RATIO; i++) cycle(1'b1, WIDTH'(i + 1), 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        w = 32'h04030201;
        total++;
        if (obs_i_req !== 1'b1 || obs_i_dat !== w || obs_len !== LEN_W'(RATIO)) begin
            bad++; $display("FAIL last_full: got req=%b dat=%h len=%0d expected req=1 dat=%h len=%0d",
                            obs_i_req, obs_i_dat, obs_len, w, RATIO);
        end
        $display("test_last done");
    endtask
`endif

    // -------------------------------------------------------------------------
    initial begin
        idle_inputs();
        test_reset();
        test_pack();
        test_back_to_back();
        test_backpressure();
        test_random();
`ifdef EB_UPSIZE_LAST_EN
        test_last();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
